// File: rtl/clock_ctrl.sv
// Clock/reset controller: synchronizes PLL lock, holds the core in reset
// until lock has been stable for HOLD_CYCLES cycles, then generates the
// 8 MHz video, 4/8 MHz CPU and 1 MHz sound clock enables from a 32 MHz clock.
module clock_ctrl #(
   parameter int HOLD_CYCLES = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       locked,
   input  logic       restart,
   input  logic       turbo,
   output logic       sys_rst_n,
   output logic       ce_vid,
   output logic       ce_cpu,
   output logic       ce_snd,
   output logic [1:0] state
);

   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT = 2'b00,
      ST_HOLD = 2'b01,
      ST_RUN  = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      div_q, div_d;
   logic            turbo_q, turbo_d;
   logic            lock_s;
   logic            run;

   assign lock_s = sync_q[1];
   assign run    = (state_q == ST_RUN);

   // Next-state logic: lock synchronizer shift, sequencer, hold counter,
   // enable divider and the turbo latch that only changes on 8-cycle boundaries.
   always_comb begin
      sync_d  = {sync_q[0], locked};
      state_d = state_q;
      cnt_d   = '0;
      div_d   = '0;
      turbo_d = turbo_q;
      case (state_q)
         ST_WAIT: begin
            if (lock_s) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!lock_s)               state_d = ST_WAIT;
            else if (cnt_q == CNT_LAST) state_d = ST_RUN;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         ST_RUN: begin
            if (!lock_s)      state_d = ST_WAIT;
            else if (restart) state_d = ST_HOLD;
            else              div_d   = div_q + 5'd1;
         end
         default: state_d = ST_WAIT;
      endcase
      if (!run || (div_q[2:0] == 3'd7)) turbo_d = turbo;
   end

   // State registers, all cleared asynchronously by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
         sync_q  <= '0;
         cnt_q   <= '0;
         div_q   <= '0;
         turbo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         turbo_q <= turbo_d;
      end
   end

   // Outputs decode only registered state, so reset forces them low at once.
   assign state     = state_q;
   assign sys_rst_n = run;
   assign ce_vid    = run && (div_q[1:0] == 2'd3);
   assign ce_snd    = run && (div_q == 5'd31);
   assign ce_cpu    = run && (turbo_q ? (div_q[1:0] == 2'd3) : (div_q[2:0] == 3'd7));

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with HOLD_CYCLES=16: directed sequences
// plus randomized lock/restart/turbo stimulus against a cycle-count model.
`timescale 1ns/1ps
module tb_clock_ctrl;

   localparam int HOLD = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       locked = 1'b0;
   logic       restart = 1'b0;
   logic       turbo = 1'b0;
   logic       sys_rst_n, ce_vid, ce_cpu, ce_snd;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   // reference model: phase 0=wait 1=hold 2=run, hold cycles seen, run cycles seen
   int m_phase = 0;
   int m_hold  = 0;
   int m_run   = 0;
   bit m_mode  = 1'b0;
   bit m_lock_a = 1'b0;
   bit m_lock_b = 1'b0;

   clock_ctrl #(.HOLD_CYCLES(HOLD)) dut (
      .clock(clock), .reset(reset), .locked(locked), .restart(restart),
      .turbo(turbo), .sys_rst_n(sys_rst_n), .ce_vid(ce_vid), .ce_cpu(ce_cpu),
      .ce_snd(ce_snd), .state(state)
   );

   // 32 MHz clock
   always #15.625 clock = ~clock;

   task automatic model_reset();
      m_phase = 0; m_hold = 0; m_run = 0; m_mode = 1'b0;
      m_lock_a = 1'b0; m_lock_b = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      bit lock_s;
      lock_s = m_lock_b;
      if (m_phase != 2 || (m_run % 8) == 7) m_mode = turbo;
      case (m_phase)
         0: if (lock_s) begin m_phase = 1; m_hold = 0; end
         1: begin
            if (!lock_s) m_phase = 0;
            else if (m_hold == HOLD - 1) begin m_phase = 2; m_run = 0; end
            else m_hold++;
         end
         default: begin
            if (!lock_s) m_phase = 0;
            else if (restart) begin m_phase = 1; m_hold = 0; end
            else m_run++;
         end
      endcase
      m_lock_b = m_lock_a;
      m_lock_a = locked;
   endtask

   function automatic logic [5:0] exp_vec();
      bit run;
      logic [1:0] st;
      run = (m_phase == 2);
      st = (m_phase == 2) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
      return {st, run, run && (m_run % 4 == 3),
              run && (m_mode ? (m_run % 4 == 3) : (m_run % 8 == 7)),
              run && (m_run % 32 == 31)};
   endfunction

   function automatic logic [5:0] dut_vec();
      return {state, sys_rst_n, ce_vid, ce_cpu, ce_snd};
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b0; locked = 1'b0; restart = 1'b0; turbo = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (dut_vec() !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got %b expected %b", i, dut_vec(), 6'b0);
         end
      end
   endtask

   task automatic test_lock_sequence();
      int first_hold = -1, first_run = -1, first_vid = -1;
      do_reset();
      tick();
      locked = 1'b1;
      for (int k = 0; k < 26; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL lock_seq cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
         if (state == 2'b01 && first_hold < 0) first_hold = k;
         if (state == 2'b10 && sys_rst_n && first_run < 0) first_run = k;
         if (ce_vid && first_vid < 0) first_vid = k;
      end
      checks++;
      if (first_hold !== 2) begin errors++; $display("FAIL first_hold: got %0d expected 2", first_hold); end
      checks++;
      if (first_run !== 18) begin errors++; $display("FAIL first_run: got %0d expected 18", first_run); end
      checks++;
      if (first_vid !== 21) begin errors++; $display("FAIL first_vid: got %0d expected 21", first_vid); end
   endtask

   task automatic test_dividers();
      int n_vid = 0, n_cpu = 0, n_snd = 0;
      turbo = 1'b0;
      for (int k = 0; k < 64; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL dividers cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
         n_vid += int'(ce_vid); n_cpu += int'(ce_cpu); n_snd += int'(ce_snd);
         if (ce_snd) begin
            checks++;
            if ({ce_vid, ce_cpu} !== 2'b11) begin
               errors++;
               $display("FAIL snd_coincide cyc %0d: got vid/cpu %b expected 11", k, {ce_vid, ce_cpu});
            end
         end
      end
      checks++;
      if (n_vid !== 16) begin errors++; $display("FAIL vid_count: got %0d expected 16", n_vid); end
      checks++;
      if (n_cpu !== 8) begin errors++; $display("FAIL cpu_count: got %0d expected 8", n_cpu); end
      checks++;
      if (n_snd !== 2) begin errors++; $display("FAIL snd_count: got %0d expected 2", n_snd); end
   endtask

   task automatic test_turbo_switch();
      int last_cpu = -100;
      int guard = 0;
      turbo = 1'b0;
      while (!(m_phase == 2 && (m_run % 8) == 2) && guard < 64) begin
         tick(); guard++;
      end
      checks++;
      if (guard >= 64) begin errors++; $display("FAIL turbo_align: got timeout expected div=2"); end
      turbo = 1'b1;
      for (int k = 0; k < 200; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL turbo cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
         if (ce_cpu) begin
            checks++;
            if (k - last_cpu < 4) begin
               errors++;
               $display("FAIL cpu_gap cyc %0d: got gap %0d expected >=4", k, k - last_cpu);
            end
            last_cpu = k;
         end
         if (k > 10 && $urandom_range(0, 5) == 0) turbo = ~turbo;
      end
   endtask

   task automatic test_lock_glitch();
      do_reset();
      locked = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL glitch cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_restart();
      // restart alone from RUN
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec() || state !== 2'b01) begin
         errors++;
         $display("FAIL restart_hold: got %b expected %b", dut_vec(), exp_vec());
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL restart cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
      end
      // restart in the same cycle lock_s falls
      locked = 1'b0;
      tick();
      tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec() || state !== 2'b00) begin
         errors++;
         $display("FAIL restart_lockloss: got %b expected %b", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_async_reset();
      locked = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec() !== 6'b0) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", dut_vec(), 6'b0);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         locked  = ($urandom_range(0, 99) < 97);
         restart = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 7) == 0) turbo = ~turbo;
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %b expected %b", k, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_dividers();
      test_turbo_switch();
      test_restart();
      test_lock_glitch();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
